// File: rtl/sha_msg_loader.sv
// SHA-256 message front end: debounced buttons collect switch bytes into one
// padded 512-bit block, pulse start to the core, then hold the block until finished.
module sha_msg_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned MAX_BYTES       = 55
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [7:0]   sw_data,
   input  logic         btn_load,
   input  logic         btn_go,
   input  logic         btn_clear,
   input  logic         finished,
   output logic [511:0] msg_block,
   output logic         start,
   output logic         busy,
   output logic [5:0]   byte_count,
   output logic         overflow
);

   localparam int unsigned BLOCK_W   = 512;
   localparam int unsigned CNT_W     = 6;
   localparam int unsigned NBTN      = 3;
   localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned BTN_LOAD  = 0;
   localparam int unsigned BTN_GO    = 1;
   localparam int unsigned BTN_CLEAR = 2;

   typedef enum logic [2:0] {
      S_COLLECT,
      S_PAD,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [NBTN-1:0]       btn_raw;
   logic [NBTN-1:0]       sync1, sync2, level, pulse;
   logic [DB_W-1:0]       db_cnt [NBTN];
   logic [BLOCK_W-1:0]    msg_d;
   logic [CNT_W-1:0]      count_d;
   logic                  ovf_d;
   logic                  start_d;
   logic                  busy_d;
   logic [8:0]            wr_lo;

   assign btn_raw = {btn_clear, btn_go, btn_load};

   // Low bit of the byte slot selected by byte_count (byte 0 sits at [511:504]).
   assign wr_lo = 9'(9'd504 - {byte_count, 3'b000});

   // Button synchronisers and debouncers; one pulse per accepted rising level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         level <= '0;
         pulse <= '0;
         for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         pulse <= '0;
         for (int i = 0; i < NBTN; i++) begin
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               level[i]  <= sync2[i];
               pulse[i]  <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_COLLECT;
         msg_block  <= '0;
         byte_count <= '0;
         overflow   <= 1'b0;
         start      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         msg_block  <= msg_d;
         byte_count <= count_d;
         overflow   <= ovf_d;
         start      <= start_d;
         busy       <= busy_d;
      end
   end

   // Next state, block edits and output decode; clear beats go beats load.
   always_comb begin
      state_d = state_q;
      msg_d   = msg_block;
      count_d = byte_count;
      ovf_d   = overflow;
      case (state_q)
         S_COLLECT: begin
            if (pulse[BTN_CLEAR]) begin
               msg_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end else if (pulse[BTN_GO]) begin
               state_d = S_PAD;
            end else if (pulse[BTN_LOAD]) begin
               if (byte_count < CNT_W'(MAX_BYTES)) begin
                  msg_d[wr_lo +: 8] = sw_data;
                  count_d           = byte_count + CNT_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         S_PAD: begin
            msg_d[wr_lo +: 8] = 8'h80;
            msg_d[63:0]       = 64'({byte_count, 3'b000});
            state_d           = S_START;
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (finished) state_d = S_DONE;
         end
         S_DONE: begin
            if (pulse[BTN_CLEAR]) begin
               msg_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = S_COLLECT;
            end
         end
         default: state_d = S_COLLECT;
      endcase
      start_d = (state_d == S_START);
      busy_d  = (state_d == S_PAD) || (state_d == S_START) || (state_d == S_WAIT);
   end

endmodule

// File: tb/tb_sha_msg_loader.sv
// Bench for sha_msg_loader: directed cases plus randomized messages, with a
// monitor that checks every start pulse against a queue of expected blocks.
module tb_sha_msg_loader;

   localparam int unsigned DEB  = 4;
   localparam int unsigned MAXB = 55;

   logic         clock = 1'b0;
   logic         reset;
   logic [7:0]   sw_data;
   logic         btn_load, btn_go, btn_clear, finished;
   logic [511:0] msg_block;
   logic         start, busy;
   logic [5:0]   byte_count;
   logic         overflow;

   int checks = 0;
   int errors = 0;
   int start_seen = 0;
   logic [511:0] exp_q[$];
   logic [7:0]   model_bytes[$];
   logic         model_ovf = 1'b0;
   logic         busy_d1 = 1'b0, busy_d2 = 1'b0;

   sha_msg_loader #(.DEBOUNCE_CYCLES(DEB), .MAX_BYTES(MAXB)) dut (
      .clock(clock), .reset(reset), .sw_data(sw_data), .btn_load(btn_load),
      .btn_go(btn_go), .btn_clear(btn_clear), .finished(finished),
      .msg_block(msg_block), .start(start), .busy(busy),
      .byte_count(byte_count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Message bytes placed big-endian from the top, no padding.
   function automatic logic [511:0] raw_block();
      logic [511:0] b = '0;
      for (int i = 0; i < model_bytes.size(); i++) b[511 - 8*i -: 8] = model_bytes[i];
      return b;
   endfunction

   // SHA-256 single-block padding: 0x80 marker after the message, bit length in last 64 bits.
   function automatic logic [511:0] padded_block();
      logic [511:0] b = raw_block();
      int n = model_bytes.size();
      b[511 - 8*n -: 8] = 8'h80;
      b[63:0] = 64'(n * 8);
      return b;
   endfunction

   // Monitor: every start pulse must carry the next expected block, preceded by one PAD cycle.
   always @(negedge clock) begin
      if (start) begin
         start_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: start=1 with no go pending");
         end else begin
            check("start_block", msg_block, exp_q.pop_front());
            check("busy_history_before_start", 512'({busy_d2, busy_d1}), 512'(2'b01));
         end
      end
      busy_d2 = busy_d1;
      busy_d1 = busy;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press(input int which, input int hold);
      case (which)
         0: btn_load = 1'b1;
         1: btn_go = 1'b1;
         default: btn_clear = 1'b1;
      endcase
      tick(hold);
      btn_load = 1'b0;
      btn_go = 1'b0;
      btn_clear = 1'b0;
      tick(14);
   endtask

   task automatic load_byte(input logic [7:0] b);
      sw_data = b;
      press(0, 10);
      if (model_bytes.size() < MAXB) model_bytes.push_back(b);
      else model_ovf = 1'b1;
   endtask

   task automatic model_clear();
      model_bytes.delete();
      model_ovf = 1'b0;
   endtask

   task automatic do_clear();
      press(2, 10);
      model_clear();
      check("clear_count", 512'(byte_count), 512'(0));
      check("clear_block", msg_block, '0);
      check("clear_overflow", 512'(overflow), 512'(0));
   endtask

   // Go, then confirm one start and WAIT hold; finish the hash and clear.
   task automatic go_and_finish(input int wait_cycles);
      int s0 = start_seen;
      exp_q.push_back(padded_block());
      press(1, 10);
      check("one_start_per_go", 512'(start_seen), 512'(s0 + 1));
      if (!finished) begin
         check("busy_in_wait", 512'(busy), 512'(1));
         tick(wait_cycles);
         check("block_held_in_wait", msg_block, padded_block());
         finished = 1'b1;
         tick(1);
      end
      check("busy_low_done", 512'(busy), 512'(0));
      check("block_held_done", msg_block, padded_block());
      finished = 1'b0;
      do_clear();
   endtask

   initial begin
      logic [511:0] abc_exp;
      logic [511:0] empty_exp;
      logic [511:0] snap;
      int n;
      reset = 1'b1;
      sw_data = '0;
      btn_load = 1'b0;
      btn_go = 1'b0;
      btn_clear = 1'b0;
      finished = 1'b0;
      tick(3);
      check("reset_block", msg_block, '0);
      check("reset_count", 512'(byte_count), 512'(0));
      check("reset_outputs", 512'({start, busy, overflow}), 512'(0));
      reset = 1'b0;
      tick(2);

      // "abc"
      abc_exp = '0;
      abc_exp[511:480] = 32'h61626380;
      abc_exp[63:0] = 64'h18;
      load_byte(8'h61);
      load_byte(8'h62);
      load_byte(8'h63);
      check("abc_count", 512'(byte_count), 512'(3));
      check("abc_model", padded_block(), abc_exp);
      exp_q.push_back(abc_exp);
      begin
         int s0 = start_seen;
         press(1, 10);
         check("abc_start_once", 512'(start_seen), 512'(s0 + 1));
      end
      check("abc_block", msg_block, abc_exp);
      check("abc_busy", 512'(busy), 512'(1));
      finished = 1'b1;
      tick(1);
      check("abc_done_busy", 512'(busy), 512'(0));
      finished = 1'b0;
      do_clear();

      // Empty message
      empty_exp = '0;
      empty_exp[511:504] = 8'h80;
      exp_q.push_back(empty_exp);
      press(1, 10);
      check("empty_block", msg_block, empty_exp);
      finished = 1'b1;
      tick(1);
      finished = 1'b0;
      do_clear();

      // Overflow: 56 loads against a 55-byte limit
      for (int i = 0; i < 56; i++) load_byte(8'($urandom));
      check("ovf_count", 512'(byte_count), 512'(55));
      check("ovf_flag", 512'(overflow), 512'(model_ovf));
      check("ovf_block", msg_block, raw_block());
      do_clear();

      // Glitch shorter than the debounce window, then a long hold
      load_byte(8'hA5);
      sw_data = 8'h3C;
      btn_load = 1'b1;
      tick(3);
      btn_load = 1'b0;
      tick(15);
      check("glitch_ignored", 512'(byte_count), 512'(1));
      press(0, 20);
      model_bytes.push_back(8'h3C);
      check("held_one_byte", 512'(byte_count), 512'(2));
      check("held_block", msg_block, raw_block());

      // Buttons in WAIT and DONE are ignored except clear in DONE
      exp_q.push_back(padded_block());
      press(1, 10);
      snap = msg_block;
      press(0, 10);
      press(1, 10);
      press(2, 10);
      check("wait_block_hold", msg_block, snap);
      check("wait_count_hold", 512'(byte_count), 512'(2));
      check("wait_busy_hold", 512'(busy), 512'(1));
      finished = 1'b1;
      tick(1);
      check("wait_to_done", 512'(busy), 512'(0));
      finished = 1'b0;
      press(0, 10);
      press(1, 10);
      check("done_ignores_load_go", msg_block, snap);
      do_clear();

      // Reset while waiting for the core
      load_byte(8'h11);
      load_byte(8'h22);
      exp_q.push_back(padded_block());
      press(1, 10);
      #2 reset = 1'b1;
      #1;
      check("rst_wait_block", msg_block, '0);
      check("rst_wait_outputs", 512'({start, busy, overflow}), 512'(0));
      check("rst_wait_count", 512'(byte_count), 512'(0));
      tick(2);
      check("rst_hold_start", 512'(start), 512'(0));
      reset = 1'b0;
      model_clear();
      tick(2);

      // Randomized messages; one round with finished already high at go
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(0, 55);
         for (int i = 0; i < n; i++) load_byte(8'($urandom));
         check("rand_count", 512'(byte_count), 512'(model_bytes.size()));
         if (r == 3) finished = 1'b1;
         go_and_finish($urandom_range(0, 5));
      end

      tick(4);
      check("all_starts_seen", 512'(exp_q.size()), 512'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
